decoder_n_seq: RTL and testbench

Parametrised, registered one-hot decoder with built-in sequencing modes; next generation of the fixed 2/3/5-bit gate decoders. Decodes an SEL_W-bit select into 2^SEL_W registered one-hot enables for direct addressing. It also generates enables autonomously, either as a one-shot sweep for register-file clear or as a continuous rotating scan for display/bank multiplexing. Sits between the processor's write-address path and the register file / peripheral bank enables.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/onehot_dec.sv | 17 +
 rtl/decoder_n_seq.sv | 127 ++++++++++++
 tb/tb_decoder_n_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the sequencing one-hot decoder: mode select values,
// controller states and the first index used by the autonomous modes.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    // Index 0 is a hard-wired register when skip_zero is set, so sequencing starts at 1.
    function automatic int unsigned first_idx(input bit skip_zero);
        return skip_zero ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational parametrised one-hot decoder with enable; all-zero when disabled.
module onehot_dec #(
    parameter int unsigned SEL_W = 5
) (
    input  logic                    en_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [(1<<SEL_W)-1:0]   out_o
);

    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with direct addressing plus one-shot SWEEP and
// rotating SCAN sequencing; each sequenced index is held SCAN_DIV cycles.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned SCAN_DIV  = 1,
    parameter bit          SKIP_ZERO = 1'b1,
    localparam int unsigned N_OUT    = 1 << SEL_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [SEL_W-1:0] select_i,
    input  logic [1:0]       mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [N_OUT-1:0] out_o,
    output logic [SEL_W-1:0] out_index_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [SEL_W-1:0] FIRST    = SEL_W'(first_idx(SKIP_ZERO));
    localparam logic [SEL_W-1:0] IDX_LAST = '1;
    localparam logic [15:0]      DIV_LAST = 16'(SCAN_DIV - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [15:0]      div_q, div_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_index_q, out_index_d;
    logic             done_q, done_d;

    logic             dec_en;
    logic [SEL_W-1:0] dec_sel;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en_i  (dec_en),
        .sel_i (dec_sel),
        .out_o (out_d)
    );

    assign out_index_d = dec_en ? dec_sel : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        done_d  = 1'b0;
        dec_en  = 1'b0;
        dec_sel = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (mode_i == MODE_SCAN || mode_i == MODE_SWEEP)) begin
                    if (mode_i == MODE_SCAN) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_SWEEP;
                    end
                    idx_d   = FIRST;
                    div_d   = '0;
                    dec_sel = FIRST;
                    dec_en  = 1'b1;
                end else begin
                    dec_sel = select_i;
                    dec_en  = en_i && !(SKIP_ZERO && select_i == '0);
                end
            end
            ST_SCAN, ST_SWEEP: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + SEL_W'(1);
                        dec_sel = idx_q + SEL_W'(1);
                        dec_en  = 1'b1;
                    end else if (state_q == ST_SCAN) begin
                        idx_d   = FIRST;
                        dec_sel = FIRST;
                        dec_en  = 1'b1;
                    end else begin
                        // Sweep finished: outputs drop and done pulses on the same edge.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d  = div_q + 16'd1;
                    dec_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            div_q       <= '0;
            out_q       <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            out_q       <= out_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    assign out_o       = out_q;
    assign out_index_o = out_index_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

    a_out_onehot0: assert property (@(posedge clk_i) $onehot0(out_q));

endmodule

// File: tb/tb_decoder_n_seq.sv
// Scoreboard bench for decoder_n_seq: two configurations (5-bit/div2/skip0 and
// 2-bit/div1/no-skip) driven with directed vectors, checked by a negedge monitor.
module tb_decoder_n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration A: SEL_W=5, SCAN_DIV=2, SKIP_ZERO=1
    logic        a_rst, a_en, a_start, a_stop;
    logic [4:0]  a_sel;
    logic [1:0]  a_mode;
    logic [31:0] a_out;
    logic [4:0]  a_idx;
    logic        a_busy, a_done;

    // Configuration B: SEL_W=2, SCAN_DIV=1, SKIP_ZERO=0
    logic        b_rst, b_en, b_start, b_stop;
    logic [1:0]  b_sel;
    logic [1:0]  b_mode;
    logic [3:0]  b_out;
    logic [1:0]  b_idx;
    logic        b_busy, b_done;

    decoder_n_seq #(
        .SEL_W     (5),
        .SCAN_DIV  (2),
        .SKIP_ZERO (1'b1)
    ) dut_a (
        .clk_i       (clk),
        .rst_i       (a_rst),
        .en_i        (a_en),
        .select_i    (a_sel),
        .mode_i      (a_mode),
        .start_i     (a_start),
        .stop_i      (a_stop),
        .out_o       (a_out),
        .out_index_o (a_idx),
        .busy_o      (a_busy),
        .done_o      (a_done)
    );

    decoder_n_seq #(
        .SEL_W     (2),
        .SCAN_DIV  (1),
        .SKIP_ZERO (1'b0)
    ) dut_b (
        .clk_i       (clk),
        .rst_i       (b_rst),
        .en_i        (b_en),
        .select_i    (b_sel),
        .mode_i      (b_mode),
        .start_i     (b_start),
        .stop_i      (b_stop),
        .out_o       (b_out),
        .out_index_o (b_idx),
        .busy_o      (b_busy),
        .done_o      (b_done)
    );

    typedef struct {
        int unsigned cyc;
        bit          dut_b;
        string       name;
        logic [31:0] out;
        logic [4:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t        cur;
    logic [31:0] act_out;
    logic [4:0]  act_idx;
    logic        act_busy, act_done;

    // Expected state after the next rising edge.
    task automatic push(input bit dut_b, input string name, input logic [31:0] o,
                        input logic [4:0] i, input logic b, input logic d);
        exp_t e;
        e.cyc   = cyc + 1;
        e.dut_b = dut_b;
        e.name  = name;
        e.out   = o;
        e.idx   = i;
        e.busy  = b;
        e.done  = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc == cyc) begin
            cur = sb.pop_front();
            if (cur.dut_b) begin
                act_out  = {28'b0, b_out};
                act_idx  = {3'b0, b_idx};
                act_busy = b_busy;
                act_done = b_done;
            end else begin
                act_out  = a_out;
                act_idx  = a_idx;
                act_busy = a_busy;
                act_done = a_done;
            end
            n_checks++;
            if (act_out !== cur.out || act_idx !== cur.idx ||
                act_busy !== cur.busy || act_done !== cur.done) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got out=%h idx=%0d busy=%b done=%b, expected out=%h idx=%0d busy=%b done=%b",
                         cur.name, cyc, act_out, act_idx, act_busy, act_done,
                         cur.out, cur.idx, cur.busy, cur.done);
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_sel = '0; a_mode = 2'd0; a_start = 1'b0; a_stop = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_sel = '0; b_mode = 2'd0; b_start = 1'b0; b_stop = 1'b0;

        push(1'b0, "a_reset", 32'h0, 5'd0, 1'b0, 1'b0);
        push(1'b1, "b_reset", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // DIRECT
        a_en = 1'b1; a_sel = 5'd7;
        push(1'b0, "direct_sel7", 32'h0000_0080, 5'd7, 1'b0, 1'b0);
        tick();
        a_sel = 5'd0;
        push(1'b0, "direct_sel0_skip", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        a_en = 1'b0; a_sel = 5'd31;
        push(1'b0, "direct_en0", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        a_en = 1'b1;
        push(1'b0, "direct_sel31", 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        tick();

        // SWEEP with a stray start/mode/select mid-run
        a_en = 1'b0; a_mode = 2'd2; a_start = 1'b1;
        push(1'b0, "sweep_first", 32'h2, 5'd1, 1'b1, 1'b0);
        tick();
        a_start = 1'b0;
        for (int c = 1; c < 62; c++) begin
            if (c == 10) begin
                a_start = 1'b1; a_mode = 2'd1; a_en = 1'b1; a_sel = 5'd5;
            end else if (c == 11) begin
                a_start = 1'b0; a_mode = 2'd2; a_en = 1'b0;
            end
            push(1'b0, "sweep_walk", 32'h1 << (1 + c / 2), 5'(1 + c / 2), 1'b1, 1'b0);
            tick();
        end
        push(1'b0, "sweep_done", 32'h0, 5'd0, 1'b0, 1'b1);
        tick();

        // Back-to-back start in the done cycle, then reset at index 12
        a_start = 1'b1; a_mode = 2'd2;
        push(1'b0, "b2b_first", 32'h2, 5'd1, 1'b1, 1'b0);
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            push(1'b0, "sweep2_walk", 32'h1 << (1 + c / 2), 5'(1 + c / 2), 1'b1, 1'b0);
            tick();
        end
        a_rst = 1'b1;
        push(1'b0, "reset_mid_sweep", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        a_rst = 1'b0;
        push(1'b0, "post_reset_no_done", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        push(1'b0, "post_reset_idle", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // SCAN entered with start and stop both high in IDLE
        a_mode = 2'd1; a_start = 1'b1; a_stop = 1'b1;
        push(1'b0, "scan_first", 32'h2, 5'd1, 1'b1, 1'b0);
        tick();
        a_start = 1'b0; a_stop = 1'b0;
        for (int c = 1; c < 70; c++) begin
            push(1'b0, "scan_walk", 32'h1 << (1 + (c / 2) % 31), 5'(1 + (c / 2) % 31), 1'b1, 1'b0);
            tick();
        end
        a_stop = 1'b1;
        push(1'b0, "scan_stop", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        a_stop = 1'b0;
        push(1'b0, "scan_after_stop", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();

        // stop in IDLE is inert; reserved mode with start decodes directly
        a_mode = 2'd0; a_en = 1'b1; a_sel = 5'd3; a_stop = 1'b1;
        push(1'b0, "idle_stop", 32'h8, 5'd3, 1'b0, 1'b0);
        tick();
        a_stop = 1'b0; a_mode = 2'd3; a_start = 1'b1; a_sel = 5'd31;
        push(1'b0, "mode3_direct", 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        tick();
        a_start = 1'b0; a_en = 1'b0; a_mode = 2'd0;

        // Configuration B
        b_en = 1'b1; b_sel = 2'd0;
        push(1'b1, "b_direct0", 32'h1, 5'd0, 1'b0, 1'b0);
        tick();
        b_en = 1'b0; b_mode = 2'd2; b_start = 1'b1;
        push(1'b1, "b_sweep0", 32'h1, 5'd0, 1'b1, 1'b0);
        tick();
        b_start = 1'b0;
        push(1'b1, "b_sweep1", 32'h2, 5'd1, 1'b1, 1'b0);
        tick();
        push(1'b1, "b_sweep2", 32'h4, 5'd2, 1'b1, 1'b0);
        tick();
        push(1'b1, "b_sweep3", 32'h8, 5'd3, 1'b1, 1'b0);
        tick();
        push(1'b1, "b_done", 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        push(1'b1, "b_after_done", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();

        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
